// File: rtl/select_3d_array_pkg.sv
// select_3d_array_pkg
//   Shared definitions for the select_3d_array_stream block.
//   - CNT_W          : width of the accepted-beat counter
//   - DEF_*          : default array geometry, used by array_t
//   - array_t        : one ROWS x COLS array of BIT_WIDTH elements at default geometry
//   - zero_array()   : all-zero array_t
//   - sel_in_range() : true when a select index addresses an existing source
package select_3d_array_pkg;

    localparam int CNT_W         = 16;
    localparam int DEF_BIT_WIDTH = 4;
    localparam int DEF_ROWS      = 8;
    localparam int DEF_COLS      = 8;

    typedef logic [DEF_ROWS-1:0][DEF_COLS-1:0][DEF_BIT_WIDTH-1:0] array_t;

    function automatic array_t zero_array();
        return '0;
    endfunction

    function automatic logic sel_in_range(input int unsigned idx, input int unsigned sources);
        return idx < sources;
    endfunction

endpackage

// File: rtl/select_3d_array_stream_skid_buffer.sv
// array_skid_buffer
//   Two-entry valid/ready storage for one flattened array. in_ready is a
//   register, so there is no combinational path from out_ready to in_ready.
//   A beat pushed into an empty buffer is visible on out_data the next cycle.
// Ports
//   clk, rst_n           : clock, asynchronous active-low reset (empties both entries)
//   in_valid/in_ready    : upstream handshake, in_data is the pushed word
//   out_valid/out_ready  : downstream handshake, out_data is the oldest entry
module array_skid_buffer #(
    parameter int DATA_W = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    logic [DATA_W-1:0] mem_q [2];
    logic [DATA_W-1:0] mem_d [2];
    logic              rd_ptr_q, rd_ptr_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic [1:0]        count_q, count_d;
    logic              in_ready_q, in_ready_d;
    logic              push, pop;

    assign in_ready  = in_ready_q;
    assign out_valid = (count_q != 2'd0);
    assign out_data  = mem_q[rd_ptr_q];

    always_comb begin
        push     = in_valid && in_ready_q;
        pop      = out_valid && out_ready;
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = in_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        // Ready is decided one cycle ahead from the next occupancy, so the
        // upstream only stalls once both entries are actually full.
        in_ready_d = (count_d != 2'd2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0]   <= '0;
            mem_q[1]   <= '0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            in_ready_q <= 1'b1;
        end else begin
            mem_q      <= mem_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            in_ready_q <= in_ready_d;
        end
    end

endmodule

// File: rtl/select_3d_array_stream.sv
// select_3d_array_stream
//   Registered N-way selector for 3-D arrays with valid/ready handshake.
//   Each accepted beat offers SOURCES candidate arrays and an index; the
//   indexed array (or all zeros when the index is out of range) is emitted
//   one cycle later.
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : input beat handshake (in, sel)
//   sel                 : source index, SEL_W bits
//   in                  : SOURCES x ROWS x COLS elements of BIT_WIDTH bits
//   out_valid/out_ready : output beat handshake
//   out                 : selected ROWS x COLS array
//   sel_err             : sticky, set by an accepted beat with sel >= SOURCES
//   err_clr             : synchronous clear of sel_err (a new error wins)
//   beat_cnt            : accepted-beat counter, wraps at 16 bits
// Configuration
//   SELECT_3D_ARRAY_SKID_EN : when defined, output goes through a 2-entry
//   skid buffer with registered in_ready; otherwise a single output register
//   with in_ready = !out_valid || out_ready.
module select_3d_array_stream
    import select_3d_array_pkg::*;
#(
    parameter  int BIT_WIDTH = 4,
    parameter  int ROWS      = 8,
    parameter  int COLS      = 8,
    parameter  int SOURCES   = 4,
    localparam int SEL_W     = $clog2(SOURCES)
) (
    input  logic                                                clk,
    input  logic                                                rst_n,
    input  logic                                                in_valid,
    output logic                                                in_ready,
    input  logic [SEL_W-1:0]                                    sel,
    input  logic [SOURCES-1:0][ROWS-1:0][COLS-1:0][BIT_WIDTH-1:0] in,
    output logic                                                out_valid,
    input  logic                                                out_ready,
    output logic [ROWS-1:0][COLS-1:0][BIT_WIDTH-1:0]            out,
    output logic                                                sel_err,
    input  logic                                                err_clr,
    output logic [CNT_W-1:0]                                    beat_cnt
);

    logic [ROWS-1:0][COLS-1:0][BIT_WIDTH-1:0] sel_data;
    logic                                     sel_ok;
    logic                                     accept;
    logic [CNT_W-1:0]                         beat_cnt_q, beat_cnt_d;
    logic                                     sel_err_q, sel_err_d;

    always_comb begin
        sel_ok   = sel_in_range(32'(sel), 32'(SOURCES));
        sel_data = '0;
        if (sel_ok) begin
            sel_data = in[sel];
        end
    end

    assign accept = in_valid && in_ready;

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (accept) begin
            beat_cnt_d = beat_cnt_q + 16'd1;
        end
        // A fresh error outranks a clear in the same cycle.
        sel_err_d = sel_err_q;
        if (accept && !sel_ok) begin
            sel_err_d = 1'b1;
        end else if (err_clr) begin
            sel_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_q <= '0;
            sel_err_q  <= 1'b0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            sel_err_q  <= sel_err_d;
        end
    end

    assign beat_cnt = beat_cnt_q;
    assign sel_err  = sel_err_q;

`ifdef SELECT_3D_ARRAY_SKID_EN
    localparam int DATA_W = ROWS * COLS * BIT_WIDTH;

    logic [DATA_W-1:0] skid_in_data;
    logic [DATA_W-1:0] skid_out_data;

    assign skid_in_data = sel_data;
    assign out          = skid_out_data;

    array_skid_buffer #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (skid_in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (skid_out_data)
    );
`else
    logic                                     out_valid_q, out_valid_d;
    logic [ROWS-1:0][COLS-1:0][BIT_WIDTH-1:0] out_q, out_d;

    assign in_ready = !out_valid_q || out_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        out_d       = out_q;
        if (accept) begin
            // Covers the simultaneous drain+accept case: new beat replaces old.
            out_valid_d = 1'b1;
            out_d       = sel_data;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out       = out_q;
`endif

endmodule
